stream_packetizer: RTL and testbench

Transmit-side adapter that takes 32-bit words from an HLS kernel's `ap_vld`/`ap_ack` output stream and wraps each one in a 49-bit BFT packet. Each packet carries a destination leaf/port and a rolling buffer address. The block sits between a kernel output port and the BFT leaf link. It enforces credit-based flow control against the receiving leaf's 128-entry input BRAM, and replenishes credits from free-space update packets returned over the BFT.

---
 rtl/stream_packetizer.sv | 132 +++++++++++++
 tb/tb_stream_packetizer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_packetizer.sv
// Wraps 32-bit kernel words (ap_vld/ap_ack) into 49-bit BFT packets with a rolling
// receiver address, credit-based flow control and free-space credit replenishment.
module stream_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 4,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int CREDIT_INIT           = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PAYLOAD_BITS-1:0]  din_user,
  input  logic                     vld_user2pkt,
  output logic                     ack_pkt2user,
  output logic [PACKET_BITS-1:0]   dout_pkt,
  input  logic                     out_ready,
  input  logic [PACKET_BITS-1:0]   din_credit,
  input  logic                     cfg_we,
  input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
  output logic [7:0]               credit_cnt,
  output logic                     busy,
  output logic                     credit_err
);

  localparam int CTRL_BIT = PAYLOAD_BITS;
  localparam int ADDR_LSB = CTRL_BIT + 1;
  localparam int PORT_LSB = ADDR_LSB + NUM_ADDR_BITS;
  localparam int LEAF_LSB = PORT_LSB + NUM_PORT_BITS;
  localparam logic [NUM_ADDR_BITS-1:0] ADDR_ONE = 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state_q, state_d;
  logic [PAYLOAD_BITS-1:0]  hold_q, hold_d;
  logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [NUM_LEAF_BITS-1:0] leaf_q, leaf_d;
  logic [NUM_PORT_BITS-1:0] port_q, port_d;
  logic [7:0]               credit_q, credit_d;
  logic                     err_q, err_d;

  logic       pkt_valid;
  logic       send_fire;
  logic       credit_hit;
  logic [8:0] credit_sum;
  logic       credit_unused;

  // Handshake: the kernel word transfers on a cycle with vld_user2pkt & ack_pkt2user;
  // the packet transfers on a cycle with dout_pkt[48] & out_ready.
  assign pkt_valid  = (state_q == SEND) && (credit_q != 8'd0);
  assign send_fire  = pkt_valid && out_ready;
  assign credit_hit = din_credit[PACKET_BITS-1] && din_credit[CTRL_BIT]
                   && (din_credit[LEAF_LSB +: NUM_LEAF_BITS] == leaf_q)
                   && (din_credit[PORT_LSB +: NUM_PORT_BITS] == port_q);

  // Address and payload of returned update packets carry no meaning here.
  assign credit_unused = ^{din_credit[ADDR_LSB +: NUM_ADDR_BITS], din_credit[PAYLOAD_BITS-1:0]};

  assign ack_pkt2user = (state_q == IDLE) && vld_user2pkt && reset;
  assign credit_cnt   = credit_q;
  assign busy         = (state_q == SEND);
  assign credit_err   = err_q;

  always_comb begin
    dout_pkt = '0;
    if (state_q == SEND) begin
      dout_pkt = {pkt_valid, leaf_q, port_q, addr_q, 1'b0, hold_q};
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    addr_d  = addr_q;
    leaf_d  = leaf_q;
    port_d  = port_q;
    case (state_q)
      IDLE: begin
        if (ack_pkt2user) begin
          hold_d  = din_user;
          state_d = SEND;
        end else if (cfg_we) begin
          leaf_d = cfg_dest_leaf;
          port_d = cfg_dest_port;
        end
      end
      SEND: begin
        if (send_fire) begin
          addr_d  = addr_q + ADDR_ONE;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credits never underflow: a send only fires with a nonzero count.
  always_comb begin
    credit_sum = {1'b0, credit_q};
    if (send_fire) credit_sum = credit_sum - 9'd1;
    if (credit_hit) credit_sum = credit_sum + 9'(FREESPACE_UPDATE_SIZE);
    credit_d = credit_sum[7:0];
    err_d    = err_q;
    if (credit_sum > 9'(CREDIT_INIT)) begin
      credit_d = 8'(CREDIT_INIT);
      err_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      addr_q   <= '0;
      leaf_q   <= '0;
      port_q   <= '0;
      credit_q <= 8'(CREDIT_INIT);
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      addr_q   <= addr_d;
      leaf_q   <= leaf_d;
      port_q   <= port_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_stream_packetizer.sv
// Directed scenarios plus a randomized run checked against a packet-level model.
module tb_stream_packetizer;

  logic        clk;
  logic        reset;
  logic [31:0] din_user;
  logic        vld_user2pkt;
  logic        ack_pkt2user;
  logic [48:0] dout_pkt;
  logic        out_ready;
  logic [48:0] din_credit;
  logic        cfg_we;
  logic [3:0]  cfg_dest_leaf;
  logic [3:0]  cfg_dest_port;
  logic [7:0]  credit_cnt;
  logic        busy;
  logic        credit_err;

  int vectors = 0;
  int miscompares = 0;
  logic [48:0] exp_q[$];

  stream_packetizer dut (
    .clk          (clk),
    .reset        (reset),
    .din_user     (din_user),
    .vld_user2pkt (vld_user2pkt),
    .ack_pkt2user (ack_pkt2user),
    .dout_pkt     (dout_pkt),
    .out_ready    (out_ready),
    .din_credit   (din_credit),
    .cfg_we       (cfg_we),
    .cfg_dest_leaf(cfg_dest_leaf),
    .cfg_dest_port(cfg_dest_port),
    .credit_cnt   (credit_cnt),
    .busy         (busy),
    .credit_err   (credit_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; vld_user2pkt = 1'b0; out_ready = 1'b0;
    din_credit = '0; cfg_we = 1'b0; din_user = '0;
    repeat (2) step();
    reset = 1'b1;
    exp_q.delete();
  endtask

  task automatic set_dest(input logic [3:0] leaf, input logic [3:0] port);
    cfg_we = 1'b1; cfg_dest_leaf = leaf; cfg_dest_port = port;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; vld_user2pkt = 1'b1; out_ready = 1'b1; din_credit = '0; cfg_we = 1'b0;
    din_user = 32'h1234_5678;
    step(); step(); #1;
    vectors++; if (ack_pkt2user !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b want 0", ack_pkt2user); end
    vectors++; if (dout_pkt !== 49'd0) begin miscompares++; $display("FAIL reset_dout: got %h want 0", dout_pkt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (credit_cnt !== 8'd128) begin miscompares++; $display("FAIL reset_credit: got %0d want 128", credit_cnt); end
    vectors++; if (credit_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", credit_err); end
    vld_user2pkt = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic [48:0] want;
    set_dest(4'd3, 4'd2);
    din_user = 32'hDEAD_BEEF; vld_user2pkt = 1'b1; out_ready = 1'b1; #1;
    vectors++; if (ack_pkt2user !== 1'b1) begin miscompares++; $display("FAIL single_ack: got %b want 1", ack_pkt2user); end
    step();
    vld_user2pkt = 1'b0; #1;
    want = {1'b1, 4'd3, 4'd2, 7'd0, 1'b0, 32'hDEAD_BEEF};
    vectors++; if (dout_pkt !== want) begin miscompares++; $display("FAIL single_pkt: got %h want %h", dout_pkt, want); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_send: got %b want 1", busy); end
    step(); #1;
    vectors++; if (credit_cnt !== 8'd127) begin miscompares++; $display("FAIL single_credit: got %0d want 127", credit_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_done: got %b want 0", busy); end
  endtask

  task automatic test_stream_stall();
    int acks = 0;
    int sent = 0;
    logic [6:0] a = 7'd0;
    logic [31:0] w;
    do_reset();
    set_dest(4'd3, 4'd2);
    out_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      vld_user2pkt = (acks < 130);
      w = $urandom();
      din_user = w; #1;
      if (dout_pkt[48] && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL stream_pkt: got %h want none", dout_pkt);
        end else begin
          if (dout_pkt !== exp_q[0]) begin miscompares++; $display("FAIL stream_pkt: got %h want %h", dout_pkt, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        sent++;
      end
      if (ack_pkt2user) begin
        exp_q.push_back({1'b1, 4'd3, 4'd2, a, 1'b0, w});
        a++;
        acks++;
      end
      step();
    end
    #1;
    vectors++; if (acks != 129) begin miscompares++; $display("FAIL stream_acks: got %0d want 129", acks); end
    vectors++; if (sent != 128) begin miscompares++; $display("FAIL stream_sent: got %0d want 128", sent); end
    vectors++; if (ack_pkt2user !== 1'b0) begin miscompares++; $display("FAIL stream_no_third_ack: got %b want 0", ack_pkt2user); end
    vectors++; if (credit_cnt !== 8'd0) begin miscompares++; $display("FAIL stream_credit: got %0d want 0", credit_cnt); end
    vectors++; if (dout_pkt[48] !== 1'b0) begin miscompares++; $display("FAIL stream_stall_valid: got %b want 0", dout_pkt[48]); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL stream_stall_busy: got %b want 1", busy); end
    vld_user2pkt = 1'b0;
  endtask

  task automatic test_credit_resume();
    din_credit = {1'b1, 4'd3, 4'd2, 7'd5, 1'b1, 32'h0BAD_F00D}; #1;
    vectors++; if (dout_pkt[48] !== 1'b0) begin miscompares++; $display("FAIL resume_pre_valid: got %b want 0", dout_pkt[48]); end
    step();
    din_credit = '0; #1;
    vectors++; if (credit_cnt !== 8'd64) begin miscompares++; $display("FAIL resume_credit64: got %0d want 64", credit_cnt); end
    vectors++;
    if (exp_q.size() != 1) begin
      miscompares++; $display("FAIL resume_queue: got %0d entries want 1", exp_q.size());
    end else begin
      if (dout_pkt !== exp_q[0] || dout_pkt[39:33] !== 7'd0) begin
        miscompares++; $display("FAIL resume_pkt: got %h want %h", dout_pkt, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    step(); #1;
    vectors++; if (credit_cnt !== 8'd63) begin miscompares++; $display("FAIL resume_credit63: got %0d want 63", credit_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL resume_busy: got %b want 0", busy); end
  endtask

  task automatic test_bad_credit();
    logic [48:0] bad [4];
    bad[0] = {1'b1, 4'd5, 4'd2, 7'd0, 1'b1, 32'h40};
    bad[1] = {1'b1, 4'd3, 4'd2, 7'd0, 1'b0, 32'h40};
    bad[2] = {1'b0, 4'd3, 4'd2, 7'd0, 1'b1, 32'h40};
    bad[3] = {1'b1, 4'd3, 4'd9, 7'd0, 1'b1, 32'h40};
    for (int i = 0; i < 4; i++) begin
      din_credit = bad[i];
      step();
      din_credit = '0; #1;
      vectors++; if (credit_cnt !== 8'd63) begin miscompares++; $display("FAIL bad_credit_%0d: got %0d want 63", i, credit_cnt); end
    end
    din_credit = {1'b1, 4'd3, 4'd2, 7'd0, 1'b1, 32'h40};
    step();
    din_credit = '0; #1;
    vectors++; if (credit_cnt !== 8'd127) begin miscompares++; $display("FAIL good_credit: got %0d want 127", credit_cnt); end
    vectors++; if (credit_err !== 1'b0) begin miscompares++; $display("FAIL good_credit_err: got %b want 0", credit_err); end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b1;
    for (int i = 0; i < 27; i++) begin
      vld_user2pkt = 1'b1; din_user = $urandom();
      step();
      vld_user2pkt = 1'b0;
      step();
    end
    #1;
    vectors++; if (credit_cnt !== 8'd100) begin miscompares++; $display("FAIL simul_pre_credit: got %0d want 100", credit_cnt); end
    vld_user2pkt = 1'b1; din_user = $urandom();
    step();
    vld_user2pkt = 1'b0;
    din_credit = {1'b1, 4'd3, 4'd2, 7'd0, 1'b1, 32'h0}; #1;
    vectors++; if (dout_pkt[48] !== 1'b1) begin miscompares++; $display("FAIL simul_valid: got %b want 1", dout_pkt[48]); end
    step();
    din_credit = '0; #1;
    vectors++; if (credit_cnt !== 8'd128) begin miscompares++; $display("FAIL simul_saturate: got %0d want 128", credit_cnt); end
    vectors++; if (credit_err !== 1'b1) begin miscompares++; $display("FAIL simul_err: got %b want 1", credit_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL simul_busy: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    logic [48:0] want;
    logic [31:0] w;
    w = $urandom();
    out_ready = 1'b0; vld_user2pkt = 1'b1; din_user = w;
    step();
    vld_user2pkt = 1'b0; din_user = ~w; #1;
    // 128 + 1 + 27 + 1 packets have been sent since the last reset: addr 157 mod 128.
    want = {1'b1, 4'd3, 4'd2, 7'd29, 1'b0, w};
    vectors++; if (dout_pkt !== want) begin miscompares++; $display("FAIL bp_pkt: got %h want %h", dout_pkt, want); end
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      vectors++; if (dout_pkt !== want) begin miscompares++; $display("FAIL bp_hold_%0d: got %h want %h", i, dout_pkt, want); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL bp_busy_%0d: got %b want 1", i, busy); end
    end
    out_ready = 1'b1;
    step(); #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_release: got %b want 0", busy); end
    vectors++; if (credit_cnt !== 8'd127) begin miscompares++; $display("FAIL bp_credit: got %0d want 127", credit_cnt); end
  endtask

  task automatic test_mid_send_reset();
    logic [31:0] w;
    logic [48:0] want;
    out_ready = 1'b0; vld_user2pkt = 1'b1; din_user = $urandom();
    step();
    vld_user2pkt = 1'b0; reset = 1'b0;
    step();
    reset = 1'b1; #1;
    vectors++; if (dout_pkt !== 49'd0) begin miscompares++; $display("FAIL midrst_dout: got %h want 0", dout_pkt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy); end
    vectors++; if (credit_cnt !== 8'd128) begin miscompares++; $display("FAIL midrst_credit: got %0d want 128", credit_cnt); end
    vectors++; if (credit_err !== 1'b0) begin miscompares++; $display("FAIL midrst_err: got %b want 0", credit_err); end
    w = $urandom();
    out_ready = 1'b1; vld_user2pkt = 1'b1; din_user = w;
    step();
    vld_user2pkt = 1'b0; #1;
    want = {1'b1, 4'd0, 4'd0, 7'd0, 1'b0, w};
    vectors++; if (dout_pkt !== want) begin miscompares++; $display("FAIL midrst_addr0: got %h want %h", dout_pkt, want); end
    step();
  endtask

  task automatic test_random();
    int m_credit = 128;
    logic m_err = 1'b0;
    logic [3:0] m_leaf = 4'd0;
    logic [3:0] m_port = 4'd0;
    logic [6:0] m_addr = 7'd0;
    logic [48:0] pk;
    logic [48:0] want_low;
    logic exp_ack, exp_valid, fire, hit, pending;
    int r, cr;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      vld_user2pkt  = ($urandom_range(0, 9) < 7);
      out_ready     = ($urandom_range(0, 9) < 6);
      din_user      = $urandom();
      cfg_we        = ($urandom_range(0, 29) == 0);
      cfg_dest_leaf = 4'($urandom_range(0, 15));
      cfg_dest_port = 4'($urandom_range(0, 15));
      pk = {17'($urandom()), 32'($urandom())};
      r = $urandom_range(0, 99);
      if (r < 1) begin
        pk[48] = 1'b1; pk[32] = 1'b1; pk[47:44] = m_leaf; pk[43:40] = m_port;
      end else if (r >= 4) begin
        pk = '0;
      end
      din_credit = pk; #1;

      pending   = (exp_q.size() != 0);
      exp_ack   = !pending && vld_user2pkt;
      exp_valid = pending && (m_credit > 0);
      want_low  = pending ? {1'b0, exp_q[0][47:0]} : 49'd0;

      vectors++; if (ack_pkt2user !== exp_ack) begin miscompares++; $display("FAIL rnd_ack c=%0d: got %b want %b", c, ack_pkt2user, exp_ack); end
      vectors++; if (dout_pkt[48] !== exp_valid) begin miscompares++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, dout_pkt[48], exp_valid); end
      vectors++; if ({1'b0, dout_pkt[47:0]} !== want_low) begin miscompares++; $display("FAIL rnd_pkt c=%0d: got %h want %h", c, dout_pkt[47:0], want_low[47:0]); end
      vectors++; if (busy !== pending) begin miscompares++; $display("FAIL rnd_busy c=%0d: got %b want %b", c, busy, pending); end
      vectors++; if (int'(credit_cnt) != m_credit) begin miscompares++; $display("FAIL rnd_credit c=%0d: got %0d want %0d", c, credit_cnt, m_credit); end
      vectors++; if (credit_err !== m_err) begin miscompares++; $display("FAIL rnd_err c=%0d: got %b want %b", c, credit_err, m_err); end

      fire = exp_valid && out_ready;
      hit  = pk[48] && pk[32] && (pk[47:44] == m_leaf) && (pk[43:40] == m_port);
      cr = m_credit - (fire ? 1 : 0) + (hit ? 64 : 0);
      if (cr > 128) begin cr = 128; m_err = 1'b1; end
      m_credit = cr;
      if (fire) begin
        void'(exp_q.pop_front());
        m_addr++;
      end
      if (exp_ack) exp_q.push_back({1'b1, m_leaf, m_port, m_addr, 1'b0, din_user});
      else if (cfg_we && !pending) begin
        m_leaf = cfg_dest_leaf;
        m_port = cfg_dest_port;
      end
      step();
    end
    cfg_we = 1'b0; vld_user2pkt = 1'b0; din_credit = '0;
  endtask

  initial begin
    reset = 1'b0; din_user = '0; vld_user2pkt = 1'b0; out_ready = 1'b0;
    din_credit = '0; cfg_we = 1'b0; cfg_dest_leaf = '0; cfg_dest_port = '0;
    test_reset();
    test_single();
    test_stream_stall();
    test_credit_resume();
    test_bad_credit();
    test_simultaneous();
    test_backpressure();
    test_mid_send_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
